multi_mode_reg_writer: RTL
==========================

MULTI_MODE_REG_WRITER -- requirements
Module: multi_mode_reg_writer

Interface
REQ-001 Parameter NUM_REGS, default 11, SHALL be the number of transform registers per slot (width, depth, T11..T33).
REQ-002 Parameter MODE_W, default 2, SHALL be the mode-select width; NUM_MODES = 2**MODE_W.
REQ-003 Parameter CAM_W, default 1, SHALL be the camera-select width; NUM_CAMS = 2**CAM_W.
REQ-004 Parameter REG_W, default 4, SHALL be the register-index width; ADDR_W = REG_W+MODE_W+CAM_W (default 7).
REQ-005 Parameter DATA_W, default 25, SHALL be the register data width.
REQ-006 Parameter PAUSE_CYCLES, default 127, SHALL be the idle cycles between reset release and the first write.
REQ-007 Parameter TABLE, width NUM_REGS*NUM_MODES*NUM_CAMS*DATA_W, SHALL hold the defaults; entry (r,m,c) is the DATA_W slice at index (r*NUM_MODES*NUM_CAMS + m*NUM_CAMS + c).
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 i_reset_n  input  1  asynchronous, active-low reset.
REQ-010 i_enable  input  1  high = advance; low = freeze all state.
REQ-011 i_start  input  1  single-cycle request for a full rewrite of all slots.
REQ-012 i_sel_valid / i_sel_mode[MODE_W] / i_sel_cam[CAM_W]  input  request to rewrite one slot (mode, cam).
REQ-013 i_ready  input  1  downstream accepts the write when o_we && i_ready.
REQ-014 o_addr  output  ADDR_W  {reg index, mode, cam}.
REQ-015 o_data  output  DATA_W  TABLE entry for o_addr.
REQ-016 o_we, o_busy, o_configured, o_done  output  1 each  write valid, non-IDLE, all slots written, one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be PAUSE, WRITE, DONE, IDLE; mode FULL or SINGLE is latched on entry to WRITE.
REQ-018 PAUSE SHALL count PAUSE_CYCLES enabled cycles, then enter WRITE in FULL mode with o_addr = 0.
REQ-019 In WRITE, o_we SHALL be 1 and o_addr/o_data SHALL stay stable until accepted (o_we && i_ready && i_enable).
REQ-020 FULL order: cam increments fastest, then mode, then reg index (0..NUM_REGS-1), i.e. NUM_REGS*NUM_MODES*NUM_CAMS writes (88 by default) with addresses 0..87 consecutive.
REQ-021 SINGLE order: mode/cam fixed to the latched selection; reg index 0..NUM_REGS-1 (11 writes).
REQ-022 On acceptance of the last write, the FSM SHALL go to DONE; DONE lasts one cycle with o_done=1 and o_we=0, then IDLE.
REQ-023 o_configured SHALL be set in DONE after a FULL pass, cleared on entering WRITE in FULL mode, and unchanged by a SINGLE pass.
REQ-024 In IDLE, i_start SHALL enter WRITE/FULL next cycle; else i_sel_valid SHALL enter WRITE/SINGLE; i_start wins if both are asserted.
REQ-025 Requests arriving in PAUSE, WRITE or DONE SHALL be ignored (not queued).
REQ-026 i_sel_valid with i_sel_mode >= NUM_MODES or i_sel_cam >= NUM_CAMS SHALL be ignored (only reachable with non-power-of-2 overrides).
REQ-027 While i_enable=0, o_we SHALL be 0 and no counter or state SHALL change; on re-enable, operation resumes with the same o_addr.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 Throughput SHALL be one write per cycle while i_ready=1; there SHALL be no bubbles between consecutive writes.

Reset
REQ-030 While i_reset_n=0: state=PAUSE, pause count=0, o_addr=0, o_data=TABLE entry 0, o_we=0, o_configured=0, o_done=0, o_busy=1.
REQ-031 Reset assertion mid-WRITE SHALL abort immediately; after release, the full PAUSE+FULL sequence SHALL restart from address 0.

Verification
REQ-032 Reset release, i_enable=1, i_ready=1 -> o_we rises after 127 cycles; 88 writes with addr 0..87 and matching TABLE data; o_done pulses once; o_configured=1.
REQ-033 i_ready toggled pseudo-randomly during FULL pass -> each address is written exactly once, in order, with data held stable while stalled.
REQ-034 In IDLE, i_sel_valid with mode=2, cam=1 -> 11 writes at addrs 5,13,21,...,85; o_configured stays 1.
REQ-035 i_start and i_sel_valid asserted in the same IDLE cycle -> FULL pass (88 writes); i_start pulsed mid-pass -> ignored, no extra pass.
REQ-036 i_enable dropped for 10 cycles at addr 40 -> o_we=0 throughout; resumes at addr 40; total of 88 accepted writes.
REQ-037 i_reset_n pulsed low at addr 30 -> o_we=0 and o_configured=0 immediately; after release, 127-cycle pause, then writes restart at addr 0.

Source files
------------

// File: rtl/multi_mode_reg_writer.sv
// Streams a table of transform-register defaults to a register port after reset,
// and on request rewrites either every slot (FULL) or one (mode, cam) slot (SINGLE).
module multi_mode_reg_writer #(
  parameter int unsigned NUM_REGS     = 11,
  parameter int unsigned MODE_W       = 2,
  parameter int unsigned CAM_W        = 1,
  parameter int unsigned REG_W        = 4,
  parameter int unsigned DATA_W       = 25,
  parameter int unsigned PAUSE_CYCLES = 127,
  parameter logic [NUM_REGS*(2**MODE_W)*(2**CAM_W)*DATA_W-1:0] TABLE = '0
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic                          i_start,
  input  logic                          i_sel_valid,
  input  logic [MODE_W-1:0]             i_sel_mode,
  input  logic [CAM_W-1:0]              i_sel_cam,
  input  logic                          i_ready,
  output logic [REG_W+MODE_W+CAM_W-1:0] o_addr,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_we,
  output logic                          o_busy,
  output logic                          o_configured,
  output logic                          o_done
);

  localparam int unsigned NUM_MODES = 2 ** MODE_W;
  localparam int unsigned NUM_CAMS  = 2 ** CAM_W;
  localparam int unsigned SLOTS     = NUM_MODES * NUM_CAMS;
  localparam int unsigned PCNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  typedef enum logic [1:0] {StPause, StWrite, StDone, StIdle} state_e;

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pause_q, pause_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [CAM_W-1:0]    cam_q, cam_d;
  logic                full_q, full_d;
  logic                conf_q, conf_d;
  logic                last_reg, last_mode, last_cam, last_write, sel_ok;
  logic [31:0]         tbl_idx;

  assign last_reg   = (reg_q == REG_W'(NUM_REGS - 1));
  assign last_mode  = (mode_q == MODE_W'(NUM_MODES - 1));
  assign last_cam   = (cam_q == CAM_W'(NUM_CAMS - 1));
  assign last_write = full_q ? (last_reg && last_mode && last_cam) : last_reg;
  // Only matters if the mode/cam counts are ever made non-power-of-2.
  assign sel_ok     = (32'(i_sel_mode) < NUM_MODES) && (32'(i_sel_cam) < NUM_CAMS);

  // Next-state: everything freezes while i_enable is low.
  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    reg_d   = reg_q;
    mode_d  = mode_q;
    cam_d   = cam_q;
    full_d  = full_q;
    conf_d  = conf_q;
    if (i_enable) begin
      case (state_q)
        StPause: begin
          if (32'(pause_q) + 32'd1 >= PAUSE_CYCLES) begin
            state_d = StWrite;
            full_d  = 1'b1;
            conf_d  = 1'b0;
            reg_d   = '0;
            mode_d  = '0;
            cam_d   = '0;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
        StWrite: begin
          if (i_ready) begin
            if (last_write) begin
              state_d = StDone;
            end else if (full_q) begin
              // cam fastest, then mode, then register index
              if (!last_cam) begin
                cam_d = cam_q + 1'b1;
              end else begin
                cam_d = '0;
                if (!last_mode) begin
                  mode_d = mode_q + 1'b1;
                end else begin
                  mode_d = '0;
                  reg_d  = reg_q + 1'b1;
                end
              end
            end else begin
              reg_d = reg_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (full_q) conf_d = 1'b1;
          state_d = StIdle;
        end
        StIdle: begin
          if (i_start) begin
            state_d = StWrite;
            full_d  = 1'b1;
            conf_d  = 1'b0;
            reg_d   = '0;
            mode_d  = '0;
            cam_d   = '0;
          end else if (i_sel_valid && sel_ok) begin
            state_d = StWrite;
            full_d  = 1'b0;
            reg_d   = '0;
            mode_d  = i_sel_mode;
            cam_d   = i_sel_cam;
          end
        end
        default: state_d = StPause;
      endcase
    end
  end

  // State and counters; reset aborts any pass and re-arms the pause.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StPause;
      pause_q <= '0;
      reg_q   <= '0;
      mode_q  <= '0;
      cam_q   <= '0;
      full_q  <= 1'b1;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      reg_q   <= reg_d;
      mode_q  <= mode_d;
      cam_q   <= cam_d;
      full_q  <= full_d;
      conf_q  <= conf_d;
    end
  end

  // Outputs: address fields map straight onto the table index.
  always_comb begin
    tbl_idx      = 32'(reg_q) * SLOTS + 32'(mode_q) * NUM_CAMS + 32'(cam_q);
    o_addr       = {reg_q, mode_q, cam_q};
    o_data       = TABLE[tbl_idx*DATA_W +: DATA_W];
    o_we         = (state_q == StWrite) && i_enable;
    o_busy       = (state_q != StIdle);
    o_done       = (state_q == StDone) && i_enable;
    o_configured = conf_q;
  end

endmodule
